// File: rtl/debounced_pio_in.sv
// Debounced KEY/SW input port on Avalon-MM: sync, per-bit debounce, DATA/RAW regs.
// Define PIO_IN_EDGE_IRQ_EN to add edge capture (W1C), IRQ mask and level irq.
module debounced_pio_in #(
    parameter int              WIDTH           = 14,
    parameter int              DEBOUNCE_CYCLES = 500000,
    parameter logic [WIDTH-1:0] INIT_VALUE     = 'h000F,
    parameter logic [WIDTH-1:0] EDGE_RISE      = 'h3FF0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pin_in,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] cap;
    logic [31:0]      rd_mux;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= INIT_VALUE;
            sync <= INIT_VALUE;
        end else begin
            meta <= pin_in;
            sync <= meta;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [CW-1:0] cnt;
        logic          stab;

        // any cycle of agreement restarts the count, so glitches never land
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt  <= '0;
                stab <= INIT_VALUE[i];
            end else if (sync[i] == stab) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt  <= '0;
                stab <= sync[i];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign stable[i] = stab;
    end

`ifdef PIO_IN_EDGE_IRQ_EN
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] event_bits;
    logic [WIDTH-1:0] clr_bits;
    logic             irq_q;
    logic             unused_wd;

    assign event_bits = (stable & ~stable_d & EDGE_RISE)
                      | (~stable & stable_d & ~EDGE_RISE);
    assign clr_bits   = (avs_write && avs_address == 2'd2)
                      ? avs_writedata[WIDTH-1:0] : '0;

    // set is OR-ed after the clear so a same-cycle event survives
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_d <= INIT_VALUE;
            mask_q   <= '0;
            cap_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            stable_d <= stable;
            cap_q    <= (cap_q & ~clr_bits) | event_bits;
            irq_q    <= |(cap_q & mask_q);
            if (avs_write && avs_address == 2'd1)
                mask_q <= avs_writedata[WIDTH-1:0];
        end
    end

    assign mask      = mask_q;
    assign cap       = cap_q;
    assign irq       = irq_q;
    assign unused_wd = ^avs_writedata[31:WIDTH];
`else
    logic unused_wd;

    assign mask      = '0;
    assign cap       = '0;
    assign irq       = 1'b0;
    assign unused_wd = ^{avs_writedata, avs_write};
`endif

    always_comb begin
        rd_mux = '0;
        unique case (avs_address)
            2'd0:    rd_mux[WIDTH-1:0] = stable;
            2'd1:    rd_mux[WIDTH-1:0] = mask;
            2'd2:    rd_mux[WIDTH-1:0] = cap;
            default: rd_mux[WIDTH-1:0] = sync;
        endcase
    end

    // registers sampled before any same-edge write, so reads see old value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            avs_readdata <= '0;
        else if (avs_read)
            avs_readdata <= rd_mux;
    end

endmodule

// File: doc/debounced_pio_in.md
# debounced_pio_in

Avalon-MM slave input port that conditions the board's KEY and SW lines before the PULPino core reads them through the Qsys interconnect. Each input bit is synchronised, debounced with a per-bit counter, and exposed as a readable data register; selectable edges are latched into a write-1-to-clear capture register that drives a maskable level interrupt. It sits as a responder on the core's data bus, replacing a bare PIO input.

## Interface
- WIDTH, 14: number of conditioned inputs (KEY[3:0] on bits 3:0, SW[9:0] on bits 13:4).
- DEBOUNCE_CYCLES, 500000: consecutive clk cycles an input must differ from its stable value before being accepted (10 ms at 50 MHz); legal range 2..2^24.
- INIT_VALUE, 14'h000F: reset value of the debounced register (KEYs released read high).
- EDGE_RISE, 14'h3FF0: per-bit capture edge; 1 = rising, 0 = falling (KEY presses are falling).

- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous active-low reset.
- pin_in  in  WIDTH  raw asynchronous board inputs.
- avs_address  in  2  word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, registered.
- irq  out  1  level interrupt to the core.

## Operation
- Register map (word addresses): 0 DATA (RO, debounced value); 1 IRQ_MASK (RW, bits WIDTH-1:0); 2 EDGE_CAPTURE (RO, write 1 clears); 3 RAW (RO, synchronised undebounced value). Unused upper bits read 0; writes to RO registers ignored.
- Synchroniser: two flops per bit, reset to INIT_VALUE.
- Debouncer per bit: counter cleared while sync equals stable; increments each cycle while they differ; when counter == DEBOUNCE_CYCLES-1 and still differing, stable <= sync and counter <= 0. Any cycle of agreement (glitch) clears the counter.
- Edge detect: bit i event when stable[i] goes 0->1 and EDGE_RISE[i]=1, or 1->0 and EDGE_RISE[i]=0.
- EDGE_CAPTURE bit set on event; cleared by write to address 2 with writedata bit i = 1. Simultaneous event and clear on the same bit: set wins.
- irq = |(EDGE_CAPTURE & IRQ_MASK), registered.
- Simultaneous read and write to the same address: read returns the pre-write value.

## Timing
- Reset values: avs_readdata 0, irq 0, IRQ_MASK 0, EDGE_CAPTURE 0, stable and sync = INIT_VALUE, counters 0.
- Read latency 1: avs_readdata valid the cycle after avs_read; held until next read. No waitrequest; write takes effect at the clock edge where avs_write is sampled.
- Input-to-DATA latency: 2 sync cycles + DEBOUNCE_CYCLES cycles of stable difference = DEBOUNCE_CYCLES+2 edges after pin change.
- EDGE_CAPTURE set one cycle after stable changes; irq asserted one cycle after that.
- irq deasserts one cycle after the clearing write or the mask write that removes the last enabled bit.
- Reset asserted mid-debounce: all state returns to reset values immediately; no event generated by the reset itself.

## Configuration
- PIO_IN_EDGE_IRQ_EN defined: edge detection, EDGE_CAPTURE, IRQ_MASK and irq as above.
- Undefined: no edge logic; addresses 1 and 2 read 0 and ignore writes; irq tied 0. DATA and RAW unchanged.

## Test plan
- Reset with pin_in = 14'h000F, DEBOUNCE_CYCLES=4 -> read addr 0 returns 32'h0000000F, irq 0.
- Drive pin_in[0] 1->0 and hold -> DATA bit 0 clears exactly 6 edges later; EDGE_CAPTURE reads 32'h1.
- Glitch pin_in[4] high for 3 cycles then low -> DATA, RAW return to 0, EDGE_CAPTURE stays 0.
- IRQ_MASK = 32'h1, press KEY0 -> irq high 1 cycle after capture; write 32'h1 to addr 2 -> irq low next cycle.
- Event on bit 0 in same cycle as W1C of bit 0 -> EDGE_CAPTURE bit 0 remains 1, irq stays asserted.
- Assert reset_n low mid-debounce of SW bit -> all outputs reset, no capture after release with pins unchanged.
